// File: rtl/spi_mult_pkg.sv
// Shared definitions for the SPI multiplier peripheral.
//   - default operand width and synchroniser depth
//   - FSM state enumeration
//   - ctr_w(): width of a counter able to hold 0..2*width
package spi_mult_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Fixed encodings so legacy state decoders keep working.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    MULT = 3'd2,
    SEND = 3'd3,
    HOLD = 3'd4
  } state_t;

  function automatic int ctr_w(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   start      : one-cycle pulse, latches A and B and restarts the sequence
//   A, B       : WIDTH-bit unsigned operands
//   res        : 2*WIDTH-bit product (final once done is seen)
//   done       : one-cycle pulse, WIDTH clocks after start was sampled
module seq_multiplier
  import spi_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   res,
  output logic                 done
);

  localparam int MCW = $clog2(WIDTH + 1);
  localparam logic [MCW-1:0] ITER = MCW'(WIDTH);
  localparam logic [MCW-1:0] ONE  = MCW'(1);

  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [MCW-1:0]     cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      a_sh <= {{WIDTH{1'b0}}, A};
      b_sh <= B;
      acc  <= '0;
      cnt  <= ITER;
      done <= 1'b0;
    end else if (cnt != '0) begin
      acc  <= acc + (b_sh[0] ? a_sh : '0);
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - ONE;
      // Last partial product lands this edge, so done and res line up.
      done <= (cnt == ONE);
    end else begin
      done <= 1'b0;
    end
  end

  assign res = acc;

endmodule

// File: rtl/spi_mult_peripheral.sv
// SPI (mode 0, MSB first) slave that receives two WIDTH-bit operands,
// multiplies them and shifts the 2*WIDTH-bit product back out.
// Ports:
//   CLK, RST_N : system clock, asynchronous active-low reset
//   SCLK, CS   : SPI clock and active-low chip select (asynchronous)
//   MOSI       : serial data in (B first, then A)
//   MISO       : serial data out, 0 unless MISO_OE
//   MISO_OE    : drive enable, high only while sending
//   BUSY       : high while multiplying or sending
//   DONE       : one-cycle pulse when the product is loaded for sending
module spi_mult_peripheral
  import spi_mult_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SCLK,
  input  logic CS,
  input  logic MOSI,
  output logic MISO,
  output logic MISO_OE,
  output logic BUSY,
  output logic DONE
);

  localparam int PW    = 2 * WIDTH;
  localparam int CTR_W = ctr_w(WIDTH);
  localparam logic [CTR_W-1:0] NBITS = CTR_W'(PW);
  localparam logic [CTR_W-1:0] LAST  = CTR_W'(PW - 1);
  localparam logic [CTR_W-1:0] ONE   = CTR_W'(1);

  // Pin synchronisers, reset to the idle pin levels so no false edge
  // strobe appears when reset is released.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign cs_rise   =  cs_s   & ~cs_d;
  assign cs_fall   = ~cs_s   &  cs_d;

  state_t            state;
  logic [CTR_W-1:0]  cnt;
  logic [PW-1:0]     sreg;
  logic              mult_start, mult_done;
  logic [PW-1:0]     mult_res;

  // Operands: the first WIDTH bits shifted in (B) end up in the top half.
  assign mult_start = (state == RECV) && !cs_rise && (cnt == NBITS);

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (mult_start),
    .A     (sreg[WIDTH-1:0]),
    .B     (sreg[PW-1:WIDTH]),
    .res   (mult_res),
    .done  (mult_done)
  );

  // A CS rise has priority over every other event in the active states.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= RECV;
            cnt   <= '0;
            sreg  <= '0;
          end
        end
        RECV: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (cnt == NBITS) begin
            state <= MULT;
          end else if (sclk_rise) begin
            sreg <= {sreg[PW-2:0], mosi_s};
            cnt  <= cnt + ONE;
          end
        end
        MULT: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (mult_done) begin
            sreg  <= mult_res;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sclk_rise && (cnt == LAST)) begin
            state <= HOLD;
          end else if (sclk_fall && (cnt < LAST)) begin
            sreg <= {sreg[PW-2:0], 1'b0};
            cnt  <= cnt + ONE;
          end
        end
        HOLD: begin
          if (cs_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO_OE = (state == SEND);
  assign MISO    = MISO_OE & sreg[PW-1];
  assign BUSY    = (state == MULT) || (state == SEND);
  assign DONE    = (state == MULT) && mult_done && !cs_rise;

endmodule

// File: doc/spi_mult_peripheral.md
SPI_MULT_PERIPHERAL -- requirements
Module: spi_mult_peripheral

Interface
REQ-001 Parameter WIDTH, 4: operand width in bits; legal range 2..16; product width is 2*WIDTH.
REQ-002 Parameter SYNC_STAGES, 2: flip-flop depth of each pin synchroniser; legal range 2..4.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SCLK  input  1  SPI serial clock, asynchronous to CLK; period at least 8 CLK cycles.
REQ-006 CS  input  1  SPI chip select, active-low, asynchronous.
REQ-007 MOSI  input  1  SPI serial data in, asynchronous.
REQ-008 MISO  output  1  SPI serial data out; forced 0 whenever MISO_OE is 0.
REQ-009 MISO_OE  output  1  MISO drive enable; high only in state SEND.
REQ-010 BUSY  output  1  high in states MULT and SEND.
REQ-011 DONE  output  1  single-CLK pulse when the product is loaded for transmission.

Function
REQ-012 SCLK, CS and MOSI each pass through a SYNC_STAGES synchroniser; SCLK rise/fall and CS rise/fall strobes come from one extra register, i.e. SYNC_STAGES+1 CLK after the pin edge.
REQ-013 SPI mode 0: MOSI sampled on the SCLK-rise strobe; MISO updated on the SCLK-fall strobe; MSB first.
REQ-014 State machine states: IDLE, RECV, MULT, SEND, HOLD; encoding from the shared package.
REQ-015 IDLE -> RECV on the CS-fall strobe; the bit counter clears to 0.
REQ-016 RECV: each SCLK-rise strobe shifts one MOSI bit into a 2*WIDTH register; the first WIDTH bits are B and the next WIDTH bits are A.
REQ-017 RECV -> MULT on the CLK after the 2*WIDTH-th bit; the seq_multiplier start pulse is asserted that cycle.
REQ-018 MULT: shift-add, one partial product per CLK; result is valid exactly WIDTH CLK after start; unsigned arithmetic, no overflow possible at 2*WIDTH.
REQ-019 MULT -> SEND on multiplier done: product loaded into the shift register, DONE pulses, bit counter clears, MISO presents product MSB.
REQ-020 SEND: each SCLK-fall strobe advances MISO to the next bit; after 2*WIDTH-1 shifts the final SCLK-rise strobe of bit 2*WIDTH moves the state to HOLD.
REQ-021 HOLD: MISO_OE low; further SCLK edges are ignored; CS-rise strobe -> IDLE.
REQ-022 SCLK edges during MULT are ignored; the master waits at least WIDTH+SYNC_STAGES+3 CLK after its last write edge before clocking the read.
REQ-023 A CS-rise strobe in RECV, MULT or SEND aborts to IDLE on the next CLK: DONE is not pulsed, or, if already pulsed, is not repeated; BUSY and MISO_OE drop; partial data is discarded.
REQ-024 A CS-fall strobe and an SCLK strobe in the same CLK: CS is processed first; the SCLK strobe is discarded.
REQ-025 A new frame requires CS to return high; back-to-back frames without a CS rise are not supported and end in HOLD.

Reset
REQ-026 While RST_N is low: state IDLE, counters 0, shift and product registers 0, synchroniser stages set to the idle pin levels (SCLK 0, CS 1, MOSI 0).
REQ-027 Outputs in reset: MISO 0, MISO_OE 0, BUSY 0, DONE 0.
REQ-028 Reset asserted mid-operation (any state) aborts without a DONE pulse; after release the block waits for a fresh CS fall.

Structure
REQ-029 Shared package spi_mult_pkg holds the state enumeration, default WIDTH and SYNC_STAGES, and the CTR_W = clog2(2*WIDTH+1) width function.
REQ-030 One sub-module, seq_multiplier (parameter WIDTH; ports CLK, RST_N, start, A, B, res, done), holds the shift-add datapath; synchronisers, FSM and SPI shift register are in the top module.

Verification
REQ-031 WIDTH=4, frame in 8'h3A (B=3, A=A), wait, read 8 bits -> MISO 8'h1E; DONE exactly once; BUSY high from the last write bit until HOLD.
REQ-032 WIDTH=4, frame in 8'hFF -> read 8'hE1; frame in 8'h0F -> read 8'h00.
REQ-033 WIDTH=8, frame in 16'hFFFF -> read 16'hFE01; DONE exactly WIDTH CLK after the MULT entry.
REQ-034 CS raised after 5 write bits, then a full frame 8'h25 -> no DONE for the aborted frame; read 8'h0A.
REQ-035 RST_N pulsed low during MULT -> all outputs 0 immediately; next frame 8'h77 reads 8'h31.
REQ-036 SCLK toggled during MULT and after bit 8 in HOLD -> product unchanged, MISO_OE 0 in HOLD, state IDLE after CS rise.
